// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of the two ALU requesters (port 0: EX stage, port 1: address helper).
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [WIDTH-1:0]  rsp0_result;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp1_result;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result,
        input  req1_ready, rsp1_valid, rsp1_result
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result,
        output req1_ready, rsp1_valid, rsp1_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a single
// registered result slot returned to the owning port over valid/ready.
module alu_share_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [CTRL_W-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0]    alu_result
);
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e       state;
    slot_state_e       state_nxt;
    logic              rsp_owner;
    logic              rsp_owner_nxt;
    logic [WIDTH-1:0]  rsp_data;
    logic [WIDTH-1:0]  rsp_data_nxt;
    logic              last_grant;
    logic              last_grant_nxt;

    logic              rsp_pending;
    logic              rsp_drain;
    logic              slot_free;
    logic              grant_vld;
    logic              grant_id;

    assign rsp_pending = (state == SLOT_FULL);

    // last_grant resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SLOT_EMPTY;
            rsp_owner  <= 1'b0;
            rsp_data   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            rsp_owner  <= rsp_owner_nxt;
            rsp_data   <= rsp_data_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Slot may be drained and refilled in the same cycle; grants are held off during reset
    always_comb begin
        state_nxt      = state;
        rsp_owner_nxt  = rsp_owner;
        rsp_data_nxt   = rsp_data;
        last_grant_nxt = last_grant;
        grant_vld      = 1'b0;
        grant_id       = 1'b0;

        rsp_drain = rsp_pending && (rsp_owner ? bus.rsp1_ready : bus.rsp0_ready);
        slot_free = !rsp_pending || rsp_drain;

        if (rst_n && slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = !last_grant;
            end else if (bus.req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end

        if (rsp_drain) begin
            state_nxt = SLOT_EMPTY;
        end
        if (grant_vld) begin
            state_nxt      = SLOT_FULL;
            rsp_owner_nxt  = grant_id;
            rsp_data_nxt   = alu_result;
            last_grant_nxt = grant_id;
        end
    end

    assign bus.req0_ready = grant_vld && !grant_id;
    assign bus.req1_ready = grant_vld && grant_id;

    // ALU operands come from the granted port, otherwise idle at zero
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant_vld) begin
            if (grant_id) begin
                alu_a    = bus.req1_a;
                alu_b    = bus.req1_b;
                alu_ctrl = bus.req1_ctrl;
            end else begin
                alu_a    = bus.req0_a;
                alu_b    = bus.req0_b;
                alu_ctrl = bus.req0_ctrl;
            end
        end
    end

    assign bus.rsp0_valid  = rsp_pending && !rsp_owner;
    assign bus.rsp1_valid  = rsp_pending && rsp_owner;
    assign bus.rsp0_result = rsp_owner ? '0 : rsp_data;
    assign bus.rsp1_result = rsp_owner ? rsp_data : '0;
endmodule
